// File: rtl/key_debounce.sv
// key_debounce: multi-key push-button debouncer.
// Each raw pin goes through a 2-FF synchroniser and then its own debounce FSM,
// which only advances on the 100 Hz sample_tick enable. The outputs are clean
// levels and one-clk press/release pulses, all registered.
// Optional feature: define KEY_AUTOREPEAT_EN to build per-key hold counters
// that emit repeated key_press pulses while a key stays pressed.

module key_debounce_lane #(
  parameter int DEB_SAMPLES    = 3,
  parameter int HOLD_SAMPLES   = 100,
  parameter int REPEAT_SAMPLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic pressed_s,
  output logic level_o,
  output logic press_o,
  output logic rel_o
);

  typedef enum logic [1:0] {REL, PRS_CHK, PRS, REL_CHK} state_e;

  localparam logic [3:0] DEB = 4'(DEB_SAMPLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic       rpt_d;

  assign cnt_inc = cnt_q + 4'd1;

  // Next-state logic: the FSM only moves on a sample tick; pulses mark real entries only
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sample_tick) begin
      unique case (state_q)
        REL: begin
          if (pressed_s) begin
            cnt_d = 4'd1;
            if (DEB == 4'd1) begin
              state_d = PRS;
              press_d = 1'b1;
            end else begin
              state_d = PRS_CHK;
            end
          end
        end
        PRS_CHK: begin
          if (pressed_s) begin
            if (cnt_inc == DEB) begin
              state_d = PRS;
              cnt_d   = 4'd0;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // bounce while pressing: abort quietly
            state_d = REL;
            cnt_d   = 4'd0;
          end
        end
        PRS: begin
          if (!pressed_s) begin
            cnt_d = 4'd1;
            if (DEB == 4'd1) begin
              state_d = REL;
              rel_d   = 1'b1;
            end else begin
              state_d = REL_CHK;
            end
          end
        end
        REL_CHK: begin
          if (!pressed_s) begin
            if (cnt_inc == DEB) begin
              state_d = REL;
              cnt_d   = 4'd0;
              rel_d   = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // bounce while releasing: key was never let go
            state_d = PRS;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = 4'd0;
        end
      endcase
    end
    level_d = (state_d == PRS) || (state_d == REL_CHK);
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD_W = (HOLD_SAMPLES < 2) ? 1 : $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_SAMPLES);
  // reload so the next repeat lands REPEAT_SAMPLES ticks after this one
  localparam logic [HOLD_W-1:0] HOLD_RELOAD =
    (REPEAT_SAMPLES < HOLD_SAMPLES) ? HOLD_W'(HOLD_SAMPLES - REPEAT_SAMPLES) : '0;

  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;

  assign hold_inc = hold_q + HOLD_W'(1);

  // Hold counter: cleared on a fresh press, counts while PRS is held, frozen in REL_CHK
  always_comb begin
    hold_d = hold_q;
    rpt_d  = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (sample_tick && (state_q == PRS) && pressed_s) begin
      if (hold_inc == HOLD_TOP) begin
        rpt_d  = 1'b1;
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_inc;
      end
    end
  end

  // Hold counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign rpt_d = 1'b0;
`endif

  // FSM state, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REL;
      cnt_q   <= 4'd0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d | rpt_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

endmodule

module key_debounce #(
  parameter int NUM_KEYS       = 4,
  parameter int DEB_SAMPLES    = 3,
  parameter int ACTIVE_LOW     = 1,
  parameter int HOLD_SAMPLES   = 100,
  parameter int REPEAT_SAMPLES = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_any
);

  // synchronisers idle at the released pin level so reset never looks like a press
  localparam logic [NUM_KEYS-1:0] INACT = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : '0;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] pressed_s;

  // Synchroniser shift: raw pin -> stage 1 -> stage 2
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
  end

  // Two-flop synchroniser, clocked every clk regardless of the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INACT;
      sync2_q <= INACT;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign pressed_s = sync2_q ^ INACT;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_debounce_lane #(
      .DEB_SAMPLES   (DEB_SAMPLES),
      .HOLD_SAMPLES  (HOLD_SAMPLES),
      .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_tick(sample_tick),
      .pressed_s  (pressed_s[g]),
      .level_o    (key_level[g]),
      .press_o    (key_press[g]),
      .rel_o      (key_release[g])
    );
  end

  assign key_any = |key_level;

endmodule
